// File: rtl/jtag_master.sv
// JTAG master: runs SYNC/header/shift/tail TMS sequences on a divided TCK and
// returns the TDO bits captured during SHIFT as a right-aligned word.
module jtag_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO
);

  typedef enum logic [2:0] {StIdle, StSync, StHdr, StShift, StTail, StDone} state_e;

  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpIr    = 2'b01;
  localparam logic [1:0] OpIdle  = 2'b11;
  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  state_e      state_q, state_d, nxt_state;
  logic [4:0]  cnt_q, cnt_d, nxt_cnt;
  logic [7:0]  div_q, div_d;
  logic        tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [1:0]  op_q, op_d, op_sel;
  logic [4:0]  last_q, last_d, last_sel, last_in, hdr_last;
  logic [5:0]  len_m1;
  logic [31:0] data_q, data_d, data_sel;
  logic [31:0] cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic        ready_q, ready_d, synced_q, synced_d;
  logic        nxt_tms, nxt_tdi, sync_end, accept;

  // In IDLE the next-period decode looks at the incoming command directly.
  assign op_sel   = (state_q == StIdle) ? cmd_op   : op_q;
  assign data_sel = (state_q == StIdle) ? cmd_data : data_q;
  assign last_sel = (state_q == StIdle) ? last_in  : last_q;
  assign hdr_last = (op_sel == OpIr) ? 5'd3 : 5'd2;
  assign len_m1   = cmd_len - 6'd1;
  assign accept   = cmd_valid & ready_q;

  always_comb begin
    if (cmd_len == 6'd0)       last_in = 5'd0;
    else if (cmd_len > 6'd32)  last_in = 5'd31;
    else                       last_in = len_m1[4:0];
  end

  // Which period follows the one currently ending (or the first one, from IDLE).
  always_comb begin
    nxt_state = StDone;
    nxt_cnt   = '0;
    sync_end  = 1'b0;
    case (state_q)
      StIdle: begin
        if (op_sel == OpReset || !synced_q) nxt_state = StSync;
        else if (op_sel == OpIdle)          nxt_state = StShift;
        else                                nxt_state = StHdr;
      end
      StSync: begin
        if (cnt_q != 5'd5) begin
          nxt_state = StSync;
          nxt_cnt   = cnt_q + 5'd1;
        end else begin
          sync_end = 1'b1;
          if (op_sel == OpReset)     nxt_state = StDone;
          else if (op_sel == OpIdle) nxt_state = StShift;
          else                       nxt_state = StHdr;
        end
      end
      StHdr: begin
        if (cnt_q != hdr_last) begin
          nxt_state = StHdr;
          nxt_cnt   = cnt_q + 5'd1;
        end else begin
          nxt_state = StShift;
        end
      end
      StShift: begin
        if (cnt_q != last_sel) begin
          nxt_state = StShift;
          nxt_cnt   = cnt_q + 5'd1;
        end else if (op_sel == OpIdle) begin
          nxt_state = StDone;
        end else begin
          nxt_state = StTail;
        end
      end
      StTail: begin
        if (cnt_q == 5'd0) begin
          nxt_state = StTail;
          nxt_cnt   = 5'd1;
        end
      end
      default: nxt_state = StDone;
    endcase
  end

  always_comb begin
    nxt_tms = tms_q;
    nxt_tdi = 1'b0;
    case (nxt_state)
      StSync:  nxt_tms = (nxt_cnt != 5'd5);
      StHdr:   nxt_tms = (op_sel == OpIr) ? (nxt_cnt < 5'd2) : (nxt_cnt == 5'd0);
      StShift: begin
        if (op_sel == OpIdle) begin
          nxt_tms = 1'b0;
        end else begin
          nxt_tms = (nxt_cnt == last_sel);
          nxt_tdi = data_sel[nxt_cnt];
        end
      end
      StTail:  nxt_tms = (nxt_cnt == 5'd0);
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    op_d       = op_q;
    last_d     = last_q;
    data_d     = data_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    synced_d   = synced_q;
    if (state_q == StIdle) begin
      tck_d = 1'b0;
      div_d = '0;
      if (accept) begin
        op_d    = cmd_op;
        last_d  = last_in;
        data_d  = cmd_data;
        cap_d   = '0;
        state_d = nxt_state;
        cnt_d   = nxt_cnt;
        tms_d   = nxt_tms;
        tdi_d   = nxt_tdi;
      end
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end else if (div_q == DivLast) begin
      div_d = '0;
      tck_d = ~tck_q;
      if (!tck_q) begin
        if (state_q == StShift && op_q != OpIdle) cap_d[cnt_q] = TDO;
      end else begin
        // Falling TCK edge: the next period begins here.
        if (sync_end) synced_d = 1'b1;
        state_d = nxt_state;
        cnt_d   = nxt_cnt;
        tms_d   = nxt_tms;
        tdi_d   = nxt_tdi;
        if (nxt_state == StDone) rsp_data_d = cap_q;
      end
    end else begin
      div_d = div_q + 8'd1;
    end
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      div_q      <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      op_q       <= '0;
      last_q     <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      ready_q    <= 1'b0;
      synced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      op_q       <= op_d;
      last_q     <= last_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
      ready_q    <= ready_d;
      synced_q   <= synced_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = (state_q == StDone);
  assign rsp_data  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a period-list model predicts TCK/TMS/TDI every clk and
// the response word; directed commands cover sync, IR/DR, run-idle and reset.
module tb_jtag_master;

  localparam int Div = 2;
  localparam int Per = 2 * Div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        TCK, TMS, TDI, TDO;
  logic [1:0]  tdo_mode = 2'd0;

  int n_checks = 0;
  int n_fail = 0;

  // Target stand-in: 0 tie low, 1 tie high, 2 echo TDI, 3 inverted echo.
  assign TDO = (tdo_mode == 2'd2) ? TDI : (tdo_mode == 2'd3) ? ~TDI : (tdo_mode == 2'd1);

  jtag_master #(.CLK_DIV(Div)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model state: the expected TMS/TDI of every TCK period of the current command.
  bit          exp_tms[$];
  bit          exp_tdi[$];
  logic [31:0] exp_rsp;
  int          nper;
  bit          m_synced = 1'b0;
  bit          m_last_tms = 1'b1;
  bit          mon_active = 1'b0;
  int          k;
  int          dut_pulses = 0;
  logic [31:0] last_rsp = '0;

  function automatic void push(input bit t, input bit d);
    exp_tms.push_back(t);
    exp_tdi.push_back(d);
  endfunction

  task automatic build_model(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
    int n;
    logic [63:0] mask;
    logic [63:0] r;
    n = (len == 6'd0) ? 1 : (len > 6'd32) ? 32 : int'(len);
    exp_tms.delete();
    exp_tdi.delete();
    if (op == 2'b00 || !m_synced)
      for (int i = 0; i < 6; i++) push(i < 5, 1'b0);
    if (op == 2'b01 || op == 2'b10) begin
      if (op == 2'b01) begin push(1, 0); push(1, 0); push(0, 0); push(0, 0); end
      else begin push(1, 0); push(0, 0); push(0, 0); end
      for (int i = 0; i < n; i++) push(i == n - 1, data[i]);
      push(1, 0);
      push(0, 0);
    end else if (op == 2'b11) begin
      for (int i = 0; i < n; i++) push(0, 0);
    end
    mask = (64'd1 << n) - 64'd1;
    case (tdo_mode)
      2'd1: r = mask;
      2'd2: r = {32'd0, data} & mask;
      2'd3: r = {32'd0, ~data} & mask;
      default: r = '0;
    endcase
    if (op == 2'b00 || op == 2'b11) r = '0;
    exp_rsp  = r[31:0];
    nper     = exp_tms.size();
    m_synced = 1'b1;
  endtask

  // Compare process: every negedge, check outputs against the period schedule.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) dut_pulses++;
      if (!rst_n) begin
        mon_active = 1'b0;
        m_synced   = 1'b0;
        m_last_tms = 1'b1;
      end else begin
        if (mon_active) begin
          if (k < Per * nper) begin
            chk("tck", {31'd0, TCK}, {31'd0, (k % Per) >= Div});
            chk("tms", {31'd0, TMS}, {31'd0, exp_tms[k / Per]});
            chk("tdi", {31'd0, TDI}, {31'd0, exp_tdi[k / Per]});
            chk("rsp_valid_busy", {31'd0, rsp_valid}, 32'd0);
            chk("ready_busy", {31'd0, cmd_ready}, 32'd0);
          end else if (k == Per * nper) begin
            m_last_tms = exp_tms[nper - 1];
            chk("rsp_valid_done", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_data", rsp_data, exp_rsp);
            chk("tck_done", {31'd0, TCK}, 32'd0);
            chk("ready_done", {31'd0, cmd_ready}, 32'd0);
            last_rsp = rsp_data;
          end else begin
            chk("ready_after", {31'd0, cmd_ready}, 32'd1);
            mon_active = 1'b0;
          end
          k++;
        end
        if (!mon_active) begin
          chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
          chk("idle_tck", {31'd0, TCK}, 32'd0);
          chk("idle_tdi", {31'd0, TDI}, 32'd0);
          chk("idle_tms", {31'd0, TMS}, {31'd0, m_last_tms});
          chk("idle_rsp_hold", rsp_data, last_rsp);
          if (cmd_valid && cmd_ready) begin
            build_model(cmd_op, cmd_len, cmd_data);
            mon_active = 1'b1;
            k = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                       input bit hold);
    int t;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (cmd_ready !== 1'b1 && t < 2000);
    if (cmd_ready !== 1'b1) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t;
    t = 0;
    while (dut_pulses < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_count", dut_pulses, target);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    logic [15:0] s16;
    logic [5:0]  s6;
    logic [3:0]  s4;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_tck", {31'd0, TCK}, 32'd0);
    chk("rst_tms", {31'd0, TMS}, 32'd1);
    chk("rst_tdi", {31'd0, TDI}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // IR from reset: SYNC prefix, 16 periods.
    c = dut_pulses;
    issue(2'b01, 6'd4, 32'h7, 1'b0);
    chk("ir_nper", nper, 32'd16);
    s16 = '0;
    for (int p = 0; p < 16 && p < nper; p++) s16 = {s16[14:0], exp_tms[p]};
    chk("ir_tms_stream", {16'd0, s16}, 32'h0000_FB06);
    s4 = '0;
    for (int p = 10; p < 14 && p < nper; p++) s4 = {s4[2:0], exp_tdi[p]};
    chk("ir_tdi_stream", {28'd0, s4}, 32'hE);
    wait_rsp(c + 1);
    chk("ir_single_pulse", dut_pulses, c + 1);

    tdo_mode = 2'd2;
    c = dut_pulses;
    issue(2'b10, 6'd32, 32'hA5A5_F00F, 1'b0);
    chk("dr32_nper", nper, 32'd37);
    wait_rsp(c + 1);
    chk("dr32_echo", last_rsp, 32'hA5A5_F00F);

    tdo_mode = 2'd1;
    c = dut_pulses;
    issue(2'b10, 6'd8, 32'h0, 1'b0);
    wait_rsp(c + 1);
    chk("dr8_ones", last_rsp, 32'h0000_00FF);
    c = dut_pulses;
    issue(2'b10, 6'd0, 32'h0, 1'b0);
    chk("dr0_nper", nper, 32'd6);
    wait_rsp(c + 1);
    chk("dr0_ones", last_rsp, 32'h1);
    c = dut_pulses;
    issue(2'b10, 6'd40, 32'h0, 1'b0);
    chk("dr40_nper", nper, 32'd37);
    wait_rsp(c + 1);
    chk("dr40_clamp", last_rsp, 32'hFFFF_FFFF);

    tdo_mode = 2'd3;
    c = dut_pulses;
    issue(2'b01, 6'd5, 32'h15, 1'b0);
    wait_rsp(c + 1);
    chk("ir5_inv", last_rsp, 32'h0A);

    c = dut_pulses;
    issue(2'b11, 6'd10, 32'hFFFF_FFFF, 1'b0);
    chk("idle10_nper", nper, 32'd10);
    wait_rsp(c + 1);
    chk("idle10_rsp", last_rsp, 32'h0);

    c = dut_pulses;
    issue(2'b00, 6'd3, 32'h0, 1'b0);
    chk("tapreset_nper", nper, 32'd6);
    wait_rsp(c + 1);
    chk("tapreset_rsp", last_rsp, 32'h0);

    // Reset in the middle of SHIFT aborts the command; next DR re-syncs.
    tdo_mode = 2'd2;
    c = dut_pulses;
    issue(2'b10, 6'd8, 32'hFF, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tck", {31'd0, TCK}, 32'd0);
    chk("abort_tms", {31'd0, TMS}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_pulse", dut_pulses, c);
    last_rsp = '0;
    issue(2'b10, 6'd4, 32'h9, 1'b0);
    s6 = '0;
    for (int p = 0; p < 6 && p < nper; p++) s6 = {s6[4:0], exp_tms[p]};
    chk("resync_tms", {26'd0, s6}, 32'h3E);
    chk("resync_nper", nper, 32'd15);
    wait_rsp(c + 1);
    chk("resync_rsp", last_rsp, 32'h9);

    // cmd_valid held high across four commands.
    c = dut_pulses;
    issue(2'b10, 6'd3, 32'h5, 1'b1);
    issue(2'b01, 6'd6, 32'h2A, 1'b1);
    issue(2'b11, 6'd2, 32'h0, 1'b1);
    issue(2'b10, 6'd16, 32'hBEEF, 1'b0);
    wait_rsp(c + 4);
    chk("b2b_last_rsp", last_rsp, 32'hBEEF);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_no_extra", dut_pulses, c + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per TCK half-period; legal range 1..255.
REQ-002 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  master idle; command accepted when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_op  in  2  command: 00 TAP reset, 01 shift IR, 10 shift DR, 11 run-idle.
REQ-007 SHALL have port cmd_len  in  6  bit count or idle-cycle count, 1..32.
REQ-008 SHALL have port cmd_data  in  32  shift data, LSB shifted first.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle pulse at command completion.
REQ-010 SHALL have port rsp_data  out  32  captured TDO bits, right-aligned.
REQ-011 SHALL have ports TCK, TMS, TDI  out  1 each  JTAG drive to the target TAP.
REQ-012 SHALL have port TDO  in  1  JTAG return from the target TAP.

Function
REQ-013 SHALL accept a command only in IDLE and latch cmd_op, cmd_len and cmd_data on acceptance; cmd_ready low from the next cycle until rsp_valid.
REQ-014 SHALL treat cmd_len=0 as 1 and cmd_len>32 as 32.
REQ-015 SHALL run each TCK period as CLK_DIV clk cycles low, then CLK_DIV clk cycles high; TCK SHALL be held low in IDLE.
REQ-016 SHALL update TMS/TDI on the clk edge that starts a TCK low phase, and SHALL sample TDO on the clk edge that drives TCK high.
REQ-017 SHALL use the states IDLE, SYNC, HDR, SHIFT, TAIL, DONE.
REQ-018 SYNC SHALL drive five periods with TMS=1, then one period with TMS=0, and SHALL leave the TAP in Run-Test/Idle.
REQ-019 For IR, HDR SHALL drive TMS sequence 1,1,0,0; for DR, HDR SHALL drive TMS sequence 1,0,0.
REQ-020 SHIFT SHALL drive cmd_len periods, with TDI = cmd_data[i] in period i; TMS=0 in every period except the last, which has TMS=1 (Exit1).
REQ-021 TAIL SHALL drive TMS sequence 1,0 (Update, then Run-Test/Idle).
REQ-022 TAP reset (op 00) SHALL run SYNC only; run-idle (op 11) SHALL drive cmd_len periods with TMS=0 and TDI=0.
REQ-023 In SHIFT, the TDO sampled in period i SHALL go to rsp_data[i]; bits >= cmd_len SHALL be 0; rsp_data SHALL be 0 for ops 00 and 11.
REQ-024 Total TCK periods: IR = N+6; DR = N+5; reset = 6; run-idle = N.
REQ-025 SHALL keep a synced flag: cleared by reset, set when SYNC completes.
REQ-026 An IR, DR or run-idle command issued while synced=0 SHALL be preceded automatically by SYNC, adding 6 periods.
REQ-027 DONE SHALL pulse rsp_valid for exactly one clk, after the final TCK high phase ends, with TCK low.
REQ-028 rsp_data SHALL hold its value until the next rsp_valid; cmd_ready SHALL be high in the cycle after rsp_valid.
REQ-029 TDI SHALL be 0 outside SHIFT; TMS SHALL hold its last driven value in IDLE.
REQ-030 If cmd_valid is high in the same cycle as rsp_valid, the command SHALL NOT be accepted until cmd_ready is high.

Reset
REQ-031 While rst_n=0 at a clk edge: state IDLE, TCK=0, TMS=1, TDI=0, rsp_valid=0, rsp_data=0, cmd_ready=0, synced=0, all counters 0.
REQ-032 cmd_ready SHALL go high in the first cycle after rst_n returns high.
REQ-033 Reset asserted mid-command SHALL abort the command with no rsp_valid; TCK SHALL be low within one clk.

Verification
REQ-034 CLK_DIV=2; from reset, op 01, len 4, data 0x7 -> 6+10 TCK periods, each 4 clk long; TMS stream 111110 1100 0001 10; TDI stream during SHIFT 1,1,1,0; rsp_valid once.
REQ-035 Synced; op 10, len 32, data 0xA5A5_F00F; target model echoes TDI on TDO -> rsp_data=0xA5A5_F00F after 37 periods.
REQ-036 Synced; op 10, len 8; TDO tied to 1 -> rsp_data=0x0000_00FF; cmd_len=0 -> 1 shift period, rsp_data=0x1.
REQ-037 Op 11, len 10, synced -> exactly 10 TCK periods with TMS=0; rsp_data=0.
REQ-038 rst_n pulsed low mid-SHIFT -> TCK=0 and TMS=1 next clk, no rsp_valid; the next DR command is prefixed by SYNC (TMS 111110).
REQ-039 cmd_valid held high continuously -> commands accepted back-to-back, one per cmd_ready; no command lost or duplicated.
